spi_read_scheduler: RTL and testbench
=====================================

# spi_read_scheduler

Front-end sequencer for `spi_flash_read`: arbitrates read jobs from `NUM_REQ` requesters round-robin and splits any job crossing a die boundary into die-aligned segments. It drives the reader's `start_flag`/`start_addr`/`end_addr`/`mode` handshake and waits on `read_finish` for each segment. It reports per-requester completion or error, so the reader core never sees a range spanning two dies.

## Interface
- `NUM_REQ`, 2: number of requesters (2..4).
- `ADDR_W`, 32: flash byte-address width.
- `DIE_LOG2`, 25: log2 of die size in bytes (32 MiB, boundary 0x02000000).
- `TIMEOUT`, 65535: maximum cycles in WAIT before a segment is abandoned.

Ports:
- `system_clk`  in  1  sole clock, rising edge.
- `system_reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  job request; held until `req_ready`.
- `req_start_addr`  in  NUM_REQ*ADDR_W  first byte address per requester.
- `req_end_addr`  in  NUM_REQ*ADDR_W  last byte address, inclusive.
- `req_mode`  in  NUM_REQ*2  read mode, passed through to the reader.
- `req_ready`  out  NUM_REQ  one-cycle accept pulse.
- `req_done`  out  NUM_REQ  one-cycle pulse when all segments finished.
- `req_error`  out  NUM_REQ  one-cycle pulse on invalid range or timeout.
- `start_flag`  out  1  reader start, a level held until `read_finish`.
- `start_addr`  out  ADDR_W  segment start address to the reader.
- `end_addr`  out  ADDR_W  segment end address to the reader.
- `mode`  out  2  mode to the reader.
- `read_finish`  in  1  reader completion level.
- `busy`  out  1  high whenever the state is not IDLE.
- `grant_id`  out  2  index of the requester currently owning the job.

## Operation
- States: IDLE, ARB, CHECK, ISSUE, WAIT, RELEASE, DONE.
- IDLE → ARB when any `req_valid` is high.
- ARB
  - Picks the first valid requester searching from `last_grant+1`, modulo NUM_REQ.
  - Pulses `req_ready[g]`.
  - Latches the addresses and mode, and sets `grant_id`/`last_grant`.
  - Goes to CHECK.
- CHECK
  - If `end < start`: pulse `req_error[g]` and return to IDLE. Nothing is issued.
  - Otherwise go to ISSUE.
- ISSUE
  - Segment end = `cur_end` if `cur[ADDR_W-1:DIE_LOG2] == end[ADDR_W-1:DIE_LOG2]`; otherwise it is the die's last byte `{cur[ADDR_W-1:DIE_LOG2], all ones}`.
  - Drive the segment onto `start_addr`/`end_addr`/`mode`, set `start_flag=1`, clear the timeout counter, and go to WAIT.
- WAIT
  - `start_flag` and the addresses stay stable.
  - On `read_finish` sampled high: drop `start_flag`, go to RELEASE.
  - If the counter reaches TIMEOUT first: drop `start_flag`, pulse `req_error[g]`, go to RELEASE with the job aborted.
- RELEASE
  - Waits for `read_finish` low.
  - Aborted job → IDLE.
  - Segment end < job end → `cur = seg_end+1`, go to ISSUE.
  - Otherwise → DONE.
- DONE: pulse `req_done[g]`, then IDLE.
- Address arithmetic is unsigned at ADDR_W bits. `seg_end+1` never wraps, because a wrap would imply `seg_end == job end == all ones`.
- A requester dropping `req_valid` after `req_ready` has no effect on the job in flight.
- Reset values: all outputs 0, `last_grant = NUM_REQ-1` (so requester 0 wins first), state IDLE.
- Asynchronous reset mid-job drops `start_flag` immediately and discards the job. No `req_done` or `req_error` is produced.

## Timing
- `req_valid` to `req_ready`: 2 cycles (IDLE, then ARB).
- `req_ready` to `start_flag` rising: 2 cycles (CHECK, then ISSUE registered).
- `read_finish` high to `start_flag` low: 1 cycle.
- `read_finish` low to the next segment's `start_flag`: 2 cycles.
- Last `read_finish` low to `req_done`: 1 cycle.
- At most one `req_ready`, `req_done` or `req_error` bit is high in any cycle.
- `read_finish` already high on entry to WAIT counts as completion (level-sensitive).

## Structure
- Shared package `spi_flash_pkg`:
  - state enum;
  - `DIE_LOG2` default;
  - mode encodings (same set used by `spi_flash_read`).
- One sub-module, `rr_arbiter` (NUM_REQ, valid vector, last_grant → grant index plus grant-valid), purely combinational.
- The FSM, segment computation and timeout counter live in the top level.

## Test plan
- Single job, req0 0x00000000..0x00000010, reader finishes in 20 cycles: exactly one segment 0x0–0x10 is issued, then `req_done[0]`.
- Die crossing, 0x01FFFFF0..0x02000010: segments 0x01FFFFF0–0x01FFFFFF then 0x02000000–0x02000010, then a single `req_done`.
- req0 and req1 valid together, each with 0x1000..0x100F:
  - grant order is 0, 1 from reset;
  - a repeat of both is again 0, 1.
- Invalid range, start 0x200, end 0x100: `req_error[0]` pulse, `start_flag` never rises.
- Reader never asserts `read_finish` (TIMEOUT=100): `start_flag` drops after 100 WAIT cycles, `req_error` pulses, state returns to IDLE.
- Reset asserted during WAIT of a split job: outputs go to 0 asynchronously, no `req_done`, and the next job is granted to req0.

Source files
------------

// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI flash read path: scheduler states, die geometry
// default, reader mode encodings and small helpers.
package spi_flash_pkg;

   localparam int DIE_LOG2_DEF = 25;

   // Mode encodings understood by spi_flash_read
   localparam logic [1:0] MODE_SPI  = 2'd0;
   localparam logic [1:0] MODE_FAST = 2'd1;
   localparam logic [1:0] MODE_DUAL = 2'd2;
   localparam logic [1:0] MODE_QUAD = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ARB     = 3'd1,
      ST_CHECK   = 3'd2,
      ST_ISSUE   = 3'd3,
      ST_WAIT    = 3'd4,
      ST_RELEASE = 3'd5,
      ST_DONE    = 3'd6
   } sched_state_t;

   function automatic logic [3:0] idx_onehot(input logic [1:0] idx);
      logic [3:0] oh;
      case (idx)
         2'd0:    oh = 4'b0001;
         2'd1:    oh = 4'b0010;
         2'd2:    oh = 4'b0100;
         2'd3:    oh = 4'b1000;
         default: oh = 4'b0000;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/spi_read_scheduler_if.sv
// Start/finish handshake between the read scheduler and the spi_flash_read core.
interface spi_read_scheduler_if #(
   parameter int ADDR_W = 32
);
   logic              start_flag;
   logic [ADDR_W-1:0] start_addr;
   logic [ADDR_W-1:0] end_addr;
   logic [1:0]        mode;
   logic              read_finish;

   modport master (output start_flag, start_addr, end_addr, mode, input read_finish);
   modport slave  (input start_flag, start_addr, end_addr, mode, output read_finish);
endinterface

// File: rtl/spi_read_scheduler_arb.sv
// Combinational round-robin pick: first valid requester after last_grant.
module rr_arbiter #(
   parameter int NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [1:0]         last_grant,
   output logic [1:0]         grant,
   output logic               grant_valid
);
   logic [3:0] valid_pad_s;
   logic [1:0] idx_s;

   // Walk farthest-to-nearest so the nearest valid requester is written last
   always_comb begin
      valid_pad_s                = 4'b0000;
      valid_pad_s[NUM_REQ-1:0]   = valid;
      grant                      = 2'd0;
      grant_valid                = 1'b0;
      idx_s                      = 2'd0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         idx_s       = 2'((int'(last_grant) + i) % NUM_REQ);
         grant       = valid_pad_s[idx_s] ? idx_s : grant;
         grant_valid = valid_pad_s[idx_s] | grant_valid;
      end
   end
endmodule

// File: rtl/spi_read_scheduler.sv
// Round-robin read-job sequencer that splits jobs at die boundaries before
// handing die-aligned segments to the flash reader.
module spi_read_scheduler
   import spi_flash_pkg::*;
#(
   parameter int NUM_REQ  = 2,
   parameter int ADDR_W   = 32,
   parameter int DIE_LOG2 = DIE_LOG2_DEF,
   parameter int TIMEOUT  = 65535
) (
   input  logic                      system_clk,
   input  logic                      system_reset_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_start_addr,
   input  logic [NUM_REQ*ADDR_W-1:0] req_end_addr,
   input  logic [NUM_REQ*2-1:0]      req_mode,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [NUM_REQ-1:0]        req_done,
   output logic [NUM_REQ-1:0]        req_error,
   output logic                      busy,
   output logic [1:0]                grant_id,
   spi_read_scheduler_if.master      rd
);
   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [ADDR_W-1:0] DIE_MASK = {{(ADDR_W-DIE_LOG2){1'b0}}, {DIE_LOG2{1'b1}}};

   sched_state_t state_r, state_nxt_s;
   logic [1:0]         last_grant_r, last_grant_nxt_s;
   logic [1:0]         grant_id_r, grant_id_nxt_s;
   logic [ADDR_W-1:0]  cur_r, cur_nxt_s;
   logic [ADDR_W-1:0]  job_end_r, job_end_nxt_s;
   logic [1:0]         job_mode_r, job_mode_nxt_s;
   logic               start_flag_r, start_flag_nxt_s;
   logic [ADDR_W-1:0]  start_addr_r, start_addr_nxt_s;
   logic [ADDR_W-1:0]  end_addr_r, end_addr_nxt_s;
   logic [1:0]         mode_r, mode_nxt_s;
   logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
   logic               aborted_r, aborted_nxt_s;
   logic               busy_r;
   logic [NUM_REQ-1:0] ready_r, ready_nxt_s;
   logic [NUM_REQ-1:0] done_r, done_nxt_s;
   logic [NUM_REQ-1:0] error_r, error_nxt_s;

   logic [1:0]         arb_grant_s;
   logic               arb_valid_s;
   logic [3:0]         grant_oh_s, owner_oh_s;
   logic [ADDR_W-1:0]  seg_end_s;
   logic [ADDR_W-1:0]  start_arr_s [4];
   logic [ADDR_W-1:0]  end_arr_s   [4];
   logic [1:0]         mode_arr_s  [4];

   for (genvar gi = 0; gi < 4; gi++) begin : g_unpack
      if (gi < NUM_REQ) begin : g_used
         assign start_arr_s[gi] = req_start_addr[gi*ADDR_W +: ADDR_W];
         assign end_arr_s[gi]   = req_end_addr[gi*ADDR_W +: ADDR_W];
         assign mode_arr_s[gi]  = req_mode[gi*2 +: 2];
      end else begin : g_unused
         assign start_arr_s[gi] = '0;
         assign end_arr_s[gi]   = '0;
         assign mode_arr_s[gi]  = 2'd0;
      end
   end

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .valid       (req_valid),
      .last_grant  (last_grant_r),
      .grant       (arb_grant_s),
      .grant_valid (arb_valid_s)
   );

   assign grant_oh_s = idx_onehot(arb_grant_s);
   assign owner_oh_s = idx_onehot(grant_id_r);
   // Stop at the die's last byte unless the job ends inside the current die
   assign seg_end_s  = (cur_r[ADDR_W-1:DIE_LOG2] == job_end_r[ADDR_W-1:DIE_LOG2]) ?
                       job_end_r : (cur_r | DIE_MASK);

   // Next-state and next-register values for the job sequencer
   always_comb begin
      state_nxt_s      = state_r;
      last_grant_nxt_s = last_grant_r;
      grant_id_nxt_s   = grant_id_r;
      cur_nxt_s        = cur_r;
      job_end_nxt_s    = job_end_r;
      job_mode_nxt_s   = job_mode_r;
      start_flag_nxt_s = start_flag_r;
      start_addr_nxt_s = start_addr_r;
      end_addr_nxt_s   = end_addr_r;
      mode_nxt_s       = mode_r;
      cnt_nxt_s        = cnt_r;
      aborted_nxt_s    = aborted_r;
      ready_nxt_s      = '0;
      done_nxt_s       = '0;
      error_nxt_s      = '0;
      case (state_r)
         ST_IDLE: begin
            if (|req_valid) state_nxt_s = ST_ARB;
            else            state_nxt_s = ST_IDLE;
         end
         ST_ARB: begin
            if (arb_valid_s) begin
               ready_nxt_s      = grant_oh_s[NUM_REQ-1:0];
               cur_nxt_s        = start_arr_s[arb_grant_s];
               job_end_nxt_s    = end_arr_s[arb_grant_s];
               job_mode_nxt_s   = mode_arr_s[arb_grant_s];
               last_grant_nxt_s = arb_grant_s;
               grant_id_nxt_s   = arb_grant_s;
               aborted_nxt_s    = 1'b0;
               state_nxt_s      = ST_CHECK;
            end else begin
               state_nxt_s      = ST_IDLE;
            end
         end
         ST_CHECK: begin
            if (job_end_r < cur_r) begin
               error_nxt_s = owner_oh_s[NUM_REQ-1:0];
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            start_addr_nxt_s = cur_r;
            end_addr_nxt_s   = seg_end_s;
            mode_nxt_s       = job_mode_r;
            start_flag_nxt_s = 1'b1;
            cnt_nxt_s        = '0;
            state_nxt_s      = ST_WAIT;
         end
         ST_WAIT: begin
            if (rd.read_finish) begin
               start_flag_nxt_s = 1'b0;
               state_nxt_s      = ST_RELEASE;
            end else if (cnt_r == CNT_LAST) begin
               start_flag_nxt_s = 1'b0;
               error_nxt_s      = owner_oh_s[NUM_REQ-1:0];
               aborted_nxt_s    = 1'b1;
               state_nxt_s      = ST_RELEASE;
            end else begin
               cnt_nxt_s        = cnt_r + CNT_W'(1);
            end
         end
         ST_RELEASE: begin
            if (rd.read_finish) begin
               state_nxt_s = ST_RELEASE;
            end else if (aborted_r) begin
               state_nxt_s = ST_IDLE;
            end else if (end_addr_r < job_end_r) begin
               // Cannot wrap: a segment ending at all-ones is always the job's last
               cur_nxt_s   = end_addr_r + ADDR_W'(1);
               state_nxt_s = ST_ISSUE;
            end else begin
               done_nxt_s  = owner_oh_s[NUM_REQ-1:0];
               state_nxt_s = ST_DONE;
            end
         end
         ST_DONE: state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State and registered outputs; reset discards any job in flight
   always_ff @(posedge system_clk or negedge system_reset_n) begin
      if (!system_reset_n) begin
         state_r      <= ST_IDLE;
         last_grant_r <= 2'(NUM_REQ - 1);
         grant_id_r   <= 2'd0;
         cur_r        <= '0;
         job_end_r    <= '0;
         job_mode_r   <= 2'd0;
         start_flag_r <= 1'b0;
         start_addr_r <= '0;
         end_addr_r   <= '0;
         mode_r       <= 2'd0;
         cnt_r        <= '0;
         aborted_r    <= 1'b0;
         busy_r       <= 1'b0;
         ready_r      <= '0;
         done_r       <= '0;
         error_r      <= '0;
      end else begin
         state_r      <= state_nxt_s;
         last_grant_r <= last_grant_nxt_s;
         grant_id_r   <= grant_id_nxt_s;
         cur_r        <= cur_nxt_s;
         job_end_r    <= job_end_nxt_s;
         job_mode_r   <= job_mode_nxt_s;
         start_flag_r <= start_flag_nxt_s;
         start_addr_r <= start_addr_nxt_s;
         end_addr_r   <= end_addr_nxt_s;
         mode_r       <= mode_nxt_s;
         cnt_r        <= cnt_nxt_s;
         aborted_r    <= aborted_nxt_s;
         busy_r       <= (state_nxt_s != ST_IDLE);
         ready_r      <= ready_nxt_s;
         done_r       <= done_nxt_s;
         error_r      <= error_nxt_s;
      end
   end

   assign req_ready     = ready_r;
   assign req_done      = done_r;
   assign req_error     = error_r;
   assign busy          = busy_r;
   assign grant_id      = grant_id_r;
   assign rd.start_flag = start_flag_r;
   assign rd.start_addr = start_addr_r;
   assign rd.end_addr   = end_addr_r;
   assign rd.mode       = mode_r;
endmodule

// File: tb/tb_spi_read_scheduler.sv
// Self-checking bench for spi_read_scheduler: table vectors, hand-timed corner
// sequences and random jobs against a die-walk reference model.
module tb_spi_read_scheduler;
   localparam int NUM_REQ = 2;
   localparam int ADDR_W  = 32;
   localparam int TIMEOUT = 100;

   typedef struct packed {
      logic [31:0] s;
      logic [31:0] e;
      logic [1:0]  m;
   } seg_t;

   typedef struct {
      logic        r;
      logic [31:0] s;
      logic [31:0] e;
      logic [1:0]  m;
      int          lat;
      int          exp_err;
      int          exp_nseg;
   } vec_t;

   logic        system_clk = 1'b0;
   logic        system_reset_n = 1'b0;
   logic [1:0]  req_valid = 2'b00;
   logic [63:0] req_start_addr, req_end_addr;
   logic [3:0]  req_mode;
   logic [1:0]  req_ready, req_done, req_error, grant_id;
   logic        busy;
   logic [31:0] s_arr [2];
   logic [31:0] e_arr [2];
   logic [1:0]  m_arr [2];

   spi_read_scheduler_if #(.ADDR_W(ADDR_W)) rd_if ();

   spi_read_scheduler #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DIE_LOG2(25), .TIMEOUT(TIMEOUT)) dut (
      .system_clk     (system_clk),
      .system_reset_n (system_reset_n),
      .req_valid      (req_valid),
      .req_start_addr (req_start_addr),
      .req_end_addr   (req_end_addr),
      .req_mode       (req_mode),
      .req_ready      (req_ready),
      .req_done       (req_done),
      .req_error      (req_error),
      .busy           (busy),
      .grant_id       (grant_id),
      .rd             (rd_if.master)
   );

   assign req_start_addr = {s_arr[1], s_arr[0]};
   assign req_end_addr   = {e_arr[1], e_arr[0]};
   assign req_mode       = {m_arr[1], m_arr[0]};

   always #5 system_clk = ~system_clk;

   int   n_checks = 0;
   int   n_pass = 0;
   bit   hang_mode = 1'b0;
   bit   manual = 1'b0;
   int   rd_lat = 4;
   int   lat_cnt = 0;
   int   sf_cnt = 0;
   int   oh_viol = 0;
   seg_t seg_q [$];
   seg_t exp_q [$];
   vec_t vecs [8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual %0h required %0h", name, act, exp);
   endtask

   // Reader model: records each issued segment, answers after rd_lat cycles
   initial begin
      rd_if.read_finish = 1'b0;
      forever begin
         @(negedge system_clk);
         if ($countones({req_ready, req_done, req_error}) > 1) oh_viol++;
         if (rd_if.start_flag) sf_cnt++;
         if (!system_reset_n) begin
            rd_if.read_finish = 1'b0;
            lat_cnt = 0;
         end else if (manual) begin
            lat_cnt = 0;
         end else if (rd_if.read_finish) begin
            if (!rd_if.start_flag) rd_if.read_finish = 1'b0;
         end else if (rd_if.start_flag) begin
            if (lat_cnt == 0) seg_q.push_back('{rd_if.start_addr, rd_if.end_addr, rd_if.mode});
            lat_cnt++;
            if (!hang_mode && lat_cnt >= rd_lat) begin
               rd_if.read_finish = 1'b1;
               lat_cnt = 0;
            end
         end else begin
            lat_cnt = 0;
         end
      end
   end

   // Reference: one segment per die touched, clipped to the job range
   task automatic model(input logic [31:0] s, input logic [31:0] e, input logic [1:0] m, output int err);
      longint lo, hi, ss, ee;
      seg_t x;
      exp_q.delete();
      ss = longint'(s);
      ee = longint'(e);
      err = (ee < ss) ? 1 : 0;
      if (err == 0) begin
         for (longint d = ss >> 25; d <= (ee >> 25); d++) begin
            lo  = d << 25;
            hi  = lo + (64'd1 << 25) - 1;
            x.s = 32'((ss > lo) ? ss : lo);
            x.e = 32'((ee < hi) ? ee : hi);
            x.m = m;
            exp_q.push_back(x);
         end
      end
   endtask

   task automatic run_job(input logic r, input logic [31:0] s, input logic [31:0] e, input logic [1:0] m,
                          output int ev, output int ev_idx, output int rdy_lat, output int extra);
      int n;
      ev = 0; ev_idx = -1; extra = 0; rdy_lat = -1;
      @(negedge system_clk);
      s_arr[r] = s; e_arr[r] = e; m_arr[r] = m;
      req_valid[r] = 1'b1;
      n = 0;
      do begin @(negedge system_clk); n++; end while (!req_ready[r] && n < 10);
      if (req_ready[r]) rdy_lat = n;
      req_valid[r] = 1'b0;
      n = 0;
      while (ev == 0 && n < 3000) begin
         @(negedge system_clk);
         n++;
         if (req_done != 2'b00) begin ev = 1; ev_idx = req_done[1] ? 1 : 0; end
         else if (req_error != 2'b00) begin ev = 2; ev_idx = req_error[1] ? 1 : 0; end
      end
      n = 0;
      while (busy && n < 50) begin
         @(negedge system_clk);
         n++;
         if (req_done != 2'b00 || req_error != 2'b00) extra++;
      end
      if (busy) extra += 100;
   endtask

   task automatic apply(input string tag, input logic r, input logic [31:0] s, input logic [31:0] e,
                        input logic [1:0] m, input int lat, input int exp_err, input int exp_nseg);
      int ev, ev_idx, rdy_lat, extra, merr;
      seg_q.delete();
      rd_lat = lat;
      model(s, e, m, merr);
      if (exp_err < 0) exp_err = merr;
      run_job(r, s, e, m, ev, ev_idx, rdy_lat, extra);
      chk({tag, "_ready_latency"}, rdy_lat, 2);
      chk({tag, "_event"}, ev, (exp_err != 0) ? 2 : 1);
      chk({tag, "_event_idx"}, ev_idx, r);
      chk({tag, "_extra_pulses"}, extra, 0);
      if (exp_nseg >= 0) chk({tag, "_nseg"}, seg_q.size(), exp_nseg);
      chk({tag, "_nseg_model"}, seg_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < seg_q.size(); i++) begin
         chk($sformatf("%s_seg%0d", tag, i), seg_q[i], exp_q[i]);
      end
   endtask

   task automatic both_jobs(output int o0, output int o1, output int ndone);
      int n, cnt;
      o0 = -1; o1 = -1; ndone = 0; cnt = 0;
      rd_lat = 3;
      @(negedge system_clk);
      s_arr[0] = 32'h1000; e_arr[0] = 32'h100F; m_arr[0] = 2'd1;
      s_arr[1] = 32'h1000; e_arr[1] = 32'h100F; m_arr[1] = 2'd2;
      req_valid = 2'b11;
      n = 0;
      while (ndone < 2 && n < 500) begin
         @(negedge system_clk);
         n++;
         if (req_ready[0]) begin req_valid[0] = 1'b0; if (cnt == 0) o0 = 0; else o1 = 0; cnt++; end
         if (req_ready[1]) begin req_valid[1] = 1'b0; if (cnt == 0) o0 = 1; else o1 = 1; cnt++; end
         if (req_done != 2'b00) ndone++;
      end
      req_valid = 2'b00;
      n = 0;
      while (busy && n < 50) begin @(negedge system_clk); n++; end
   endtask

   initial begin
      int n, ev, ev_idx, rdy_lat, extra, o0, o1, nd, die, kind, off, merr;
      longint ls, le;
      logic r;
      logic [1:0] m;

      vecs[0] = '{1'b0, 32'h0000_0000, 32'h0000_0010, 2'd0, 20, 0, 1};
      vecs[1] = '{1'b0, 32'h01FF_FFF0, 32'h0200_0010, 2'd1,  3, 0, 2};
      vecs[2] = '{1'b0, 32'h0000_0200, 32'h0000_0100, 2'd2,  3, 1, 0};
      vecs[3] = '{1'b1, 32'h01FF_FFFF, 32'h0200_0000, 2'd3,  1, 0, 2};
      vecs[4] = '{1'b0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 2'd2,  2, 0, 1};
      vecs[5] = '{1'b1, 32'h05FF_FFFF, 32'h0A00_0000, 2'd0,  2, 0, 4};
      vecs[6] = '{1'b0, 32'h0000_1234, 32'h0000_1234, 2'd1,  1, 0, 1};
      vecs[7] = '{1'b1, 32'h0200_0000, 32'h01FF_FFFF, 2'd3,  1, 1, 0};

      for (int i = 0; i < 2; i++) begin s_arr[i] = '0; e_arr[i] = '0; m_arr[i] = 2'd0; end
      repeat (3) @(negedge system_clk);
      chk("reset_start_flag", rd_if.start_flag, 0);
      chk("reset_busy", busy, 0);
      chk("reset_grant_id", grant_id, 0);
      chk("reset_pulses", {req_ready, req_done, req_error}, 0);
      chk("reset_addrs_mode", {rd_if.start_addr, rd_if.end_addr, rd_if.mode}, 0);
      system_reset_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         apply($sformatf("vec%0d", i), vecs[i].r, vecs[i].s, vecs[i].e, vecs[i].m,
               vecs[i].lat, vecs[i].exp_err, vecs[i].exp_nseg);
      end

      // Hand-driven reader: cycle latencies around a split job
      manual = 1'b1;
      @(negedge system_clk);
      s_arr[0] = 32'h01FF_FFF8; e_arr[0] = 32'h0200_0007; m_arr[0] = 2'd3;
      req_valid[0] = 1'b1;
      n = 0;
      do begin @(negedge system_clk); n++; end while (!req_ready[0] && n < 10);
      req_valid[0] = 1'b0;
      chk("t_ready_seen", req_ready[0], 1);
      n = 0;
      do begin @(negedge system_clk); n++; end while (!rd_if.start_flag && n < 10);
      chk("t_ready_to_start", n, 2);
      repeat (3) @(negedge system_clk);
      chk("t_seg0", {rd_if.start_addr, rd_if.end_addr, rd_if.start_flag}, {32'h01FF_FFF8, 32'h01FF_FFFF, 1'b1});
      rd_if.read_finish = 1'b1;
      n = 0;
      do begin @(negedge system_clk); n++; end while (rd_if.start_flag && n < 10);
      chk("t_finish_to_drop", n, 1);
      repeat (2) @(negedge system_clk);
      rd_if.read_finish = 1'b0;
      @(negedge system_clk);
      chk("t_gap_low", rd_if.start_flag, 0);
      rd_if.read_finish = 1'b1;
      @(negedge system_clk);
      chk("t_seg1", {rd_if.start_addr, rd_if.end_addr, rd_if.start_flag}, {32'h0200_0000, 32'h0200_0007, 1'b1});
      @(negedge system_clk);
      chk("t_level_finish_drop", rd_if.start_flag, 0);
      rd_if.read_finish = 1'b0;
      @(negedge system_clk);
      chk("t_done_latency", req_done, 2'b01);
      repeat (2) @(negedge system_clk);
      manual = 1'b0;

      // Reader that never answers
      hang_mode = 1'b1;
      seg_q.delete();
      sf_cnt = 0;
      run_job(1'b1, 32'h300, 32'h310, 2'd1, ev, ev_idx, rdy_lat, extra);
      chk("to_event", ev, 2);
      chk("to_idx", ev_idx, 1);
      chk("to_start_cycles", sf_cnt, TIMEOUT);
      chk("to_nseg", seg_q.size(), 1);
      chk("to_extra", extra, 0);
      chk("to_idle", busy, 0);
      hang_mode = 1'b0;

      both_jobs(o0, o1, nd);
      chk("rr_first", o0, 0);
      chk("rr_second", o1, 1);
      chk("rr_done", nd, 2);
      both_jobs(o0, o1, nd);
      chk("rr2_first", o0, 0);
      chk("rr2_second", o1, 1);

      // Reset in the middle of a split job
      rd_lat = 40;
      @(negedge system_clk);
      s_arr[0] = 32'h01FF_FFF0; e_arr[0] = 32'h0200_0010; m_arr[0] = 2'd0;
      req_valid[0] = 1'b1;
      n = 0;
      do begin @(negedge system_clk); n++; end while (!req_ready[0] && n < 10);
      req_valid[0] = 1'b0;
      n = 0;
      do begin @(negedge system_clk); n++; end while (!rd_if.start_flag && n < 20);
      chk("rst_job_started", rd_if.start_flag, 1);
      repeat (5) @(negedge system_clk);
      #2 system_reset_n = 1'b0;
      #1;
      chk("rst_async_start_flag", rd_if.start_flag, 0);
      chk("rst_async_busy", busy, 0);
      chk("rst_async_outs", {rd_if.start_addr, rd_if.end_addr, grant_id, req_done, req_error}, 0);
      repeat (2) @(negedge system_clk);
      system_reset_n = 1'b1;
      n = 0;
      repeat (60) begin
         @(negedge system_clk);
         if (req_done != 2'b00 || req_error != 2'b00) n++;
      end
      chk("rst_no_pulses", n, 0);
      both_jobs(o0, o1, nd);
      chk("rst_first_grant", o0, 0);

      for (int k = 0; k < 16; k++) begin
         die  = int'($urandom_range(0, 127));
         kind = int'($urandom_range(0, 3));
         if (kind == 1 || kind == 2) off = (1 << 25) - int'($urandom_range(1, 64));
         else off = int'($urandom_range(64, 4096));
         ls = (longint'(die) << 25) + longint'(off);
         if (kind == 3) le = ls - longint'($urandom_range(1, 60));
         else le = ls + longint'($urandom_range(0, 96));
         if (le > 64'hFFFF_FFFF) le = 64'hFFFF_FFFF;
         r = 1'($urandom_range(0, 1));
         m = 2'($urandom_range(0, 3));
         model(ls[31:0], le[31:0], m, merr);
         apply($sformatf("rnd%0d", k), r, ls[31:0], le[31:0], m, int'($urandom_range(1, 8)), -1, -1);
      end

      chk("single_pulse_per_cycle", oh_viol, 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
